// File: rtl/core_mem_arb.sv
// core_mem_arb
//   Arbitrates an instruction-fetch port (I) and a data port (D) onto one
//   memory request/acknowledge channel. Only one transaction is ever in
//   flight. Each transaction goes through IDLE -> REQ -> WAIT -> RESP.
//   A transaction stuck in WAIT for TIMEOUT cycles is completed with zero
//   data and a one-cycle arb_err pulse.
//
//   Build option: define CORE_MEM_ARB_RR_EN to grant simultaneous I/D
//   requests round-robin. Without it, D always wins a tie.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_req_val, i_req_addr          fetch request, held until i_ack
//   i_ack, i_ack_rdata             fetch completion pulse and word
//   d_req_val/addr/cop/size/wdata  data request, held until d_ack
//   d_ack, d_ack_rdata             data completion pulse and read data
//   mem_req_val/addr/cop/size/wdata  request to memory
//   mem_req_rdy                    memory accepted the request this cycle
//   mem_ack, mem_ack_rdata         memory response
//   arb_err                        one-cycle pulse on timeout
module core_mem_arb #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_val,
  input  logic [31:0] i_req_addr,
  output logic        i_ack,
  output logic [31:0] i_ack_rdata,
  input  logic        d_req_val,
  input  logic [31:0] d_req_addr,
  input  logic [2:0]  d_req_cop,
  input  logic [2:0]  d_req_size,
  input  logic [31:0] d_req_wdata,
  output logic        d_ack,
  output logic [31:0] d_ack_rdata,
  output logic        mem_req_val,
  output logic [31:0] mem_req_addr,
  output logic [2:0]  mem_req_cop,
  output logic [2:0]  mem_req_size,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_req_rdy,
  input  logic        mem_ack,
  input  logic [31:0] mem_ack_rdata,
  output logic        arb_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  // Counter value at which the last permitted WAIT cycle is running.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        owner_d;   // 1: current transaction belongs to D
  logic [15:0] wait_cnt;
  logic        grant_d;

`ifdef CORE_MEM_ARB_RR_EN
  logic last_d;           // 1: last grant went to D
  // On a tie, the side that was not granted last wins.
  assign grant_d = d_req_val & (~i_req_val | ~last_d);
`else
  assign grant_d = d_req_val;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      owner_d       <= 1'b0;
      wait_cnt      <= '0;
      mem_req_val   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_cop   <= '0;
      mem_req_size  <= '0;
      mem_req_wdata <= '0;
      i_ack         <= 1'b0;
      i_ack_rdata   <= '0;
      d_ack         <= 1'b0;
      d_ack_rdata   <= '0;
      arb_err       <= 1'b0;
`ifdef CORE_MEM_ARB_RR_EN
      last_d        <= 1'b0;
`endif
    end else begin
      // Response outputs are single-cycle pulses.
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
      arb_err     <= 1'b0;
      i_ack_rdata <= '0;
      d_ack_rdata <= '0;
      case (state)
        IDLE: begin
          if (i_req_val || d_req_val) begin
            owner_d     <= grant_d;
            mem_req_val <= 1'b1;
            if (grant_d) begin
              mem_req_addr  <= d_req_addr;
              mem_req_cop   <= d_req_cop;
              mem_req_size  <= d_req_size;
              mem_req_wdata <= d_req_wdata;
            end else begin
              // Fetches are always word reads.
              mem_req_addr  <= i_req_addr;
              mem_req_cop   <= 3'b000;
              mem_req_size  <= 3'b010;
              mem_req_wdata <= '0;
            end
`ifdef CORE_MEM_ARB_RR_EN
            last_d <= grant_d;
`endif
            state <= REQ;
          end
        end
        REQ: begin
          // A mem_ack in the accept cycle is not a completion.
          if (mem_req_rdy) begin
            mem_req_val <= 1'b0;
            wait_cnt    <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // A real response wins over a simultaneous timeout.
          if (mem_ack || wait_cnt == WAIT_LAST) begin
            i_ack       <= ~owner_d;
            d_ack       <= owner_d;
            i_ack_rdata <= (!owner_d && mem_ack) ? mem_ack_rdata : '0;
            d_ack_rdata <= (owner_d && mem_ack) ? mem_ack_rdata : '0;
            arb_err     <= ~mem_ack;
            state       <= RESP;
          end
          if (!mem_ack) wait_cnt <= wait_cnt + 16'd1;
        end
        RESP: begin
          // Requesters still hold val here; arbitrate only from IDLE.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arb.sv
module tb_core_mem_arb;
  localparam int TMO = 8;

  logic        clk, rst_n;
  logic        i_req_val;
  logic [31:0] i_req_addr;
  logic        i_ack;
  logic [31:0] i_ack_rdata;
  logic        d_req_val;
  logic [31:0] d_req_addr;
  logic [2:0]  d_req_cop, d_req_size;
  logic [31:0] d_req_wdata;
  logic        d_ack;
  logic [31:0] d_ack_rdata;
  logic        mem_req_val;
  logic [31:0] mem_req_addr;
  logic [2:0]  mem_req_cop, mem_req_size;
  logic [31:0] mem_req_wdata;
  logic        mem_req_rdy, mem_ack;
  logic [31:0] mem_ack_rdata;
  logic        arb_err;

  int n_tests = 0;
  int n_fail  = 0;

  core_mem_arb #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_val(i_req_val), .i_req_addr(i_req_addr),
    .i_ack(i_ack), .i_ack_rdata(i_ack_rdata),
    .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_cop(d_req_cop),
    .d_req_size(d_req_size), .d_req_wdata(d_req_wdata),
    .d_ack(d_ack), .d_ack_rdata(d_ack_rdata),
    .mem_req_val(mem_req_val), .mem_req_addr(mem_req_addr),
    .mem_req_cop(mem_req_cop), .mem_req_size(mem_req_size),
    .mem_req_wdata(mem_req_wdata), .mem_req_rdy(mem_req_rdy),
    .mem_ack(mem_ack), .mem_ack_rdata(mem_ack_rdata), .arb_err(arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One transaction record: granted -> accepted by memory -> responded.
  bit          t_open, t_accepted, t_responding, t_is_d, t_err, last_was_d;
  int          t_waited;
  logic [31:0] t_addr, t_wdata, t_data;
  logic [2:0]  t_cop, t_size;
  // expected outputs after the latest edge
  bit          exp_mval, exp_i_ack, exp_d_ack, exp_err;
  logic [31:0] exp_rdata;

  function automatic bit d_wins(input bit iv, input bit dv, input bit last_d);
    if (!dv) return 1'b0;
    if (!iv) return 1'b1;
`ifdef CORE_MEM_ARB_RR_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_open = 0; t_accepted = 0; t_responding = 0; t_is_d = 0; t_err = 0;
      last_was_d = 0; t_waited = 0;
    end else if (t_responding) begin
      t_open = 0; t_responding = 0;
    end else if (!t_open) begin
      if (i_req_val || d_req_val) begin
        t_is_d = d_wins(i_req_val, d_req_val, last_was_d);
        last_was_d = t_is_d;
        t_open = 1; t_accepted = 0;
        t_addr  = t_is_d ? d_req_addr  : i_req_addr;
        t_cop   = t_is_d ? d_req_cop   : 3'd0;
        t_size  = t_is_d ? d_req_size  : 3'd2;
        t_wdata = t_is_d ? d_req_wdata : 32'd0;
      end
    end else if (!t_accepted) begin
      if (mem_req_rdy) begin t_accepted = 1; t_waited = 0; end
    end else begin
      if (mem_ack) begin
        t_responding = 1; t_data = mem_ack_rdata; t_err = 0;
      end else if (t_waited + 1 >= TMO) begin
        t_responding = 1; t_data = 32'd0; t_err = 1;
      end else begin
        t_waited++;
      end
    end
    exp_mval  = t_open && !t_accepted;
    exp_i_ack = t_responding && !t_is_d;
    exp_d_ack = t_responding && t_is_d;
    exp_err   = t_responding && t_err;
    exp_rdata = t_data;
    #1;
    check("mem_req_val", mem_req_val, exp_mval);
    check("i_ack", i_ack, exp_i_ack);
    check("d_ack", d_ack, exp_d_ack);
    check("arb_err", arb_err, exp_err);
    if (!rst_n) begin
      check("rst_addr", mem_req_addr, 0);
      check("rst_cop", mem_req_cop, 0);
      check("rst_size", mem_req_size, 0);
      check("rst_wdata", mem_req_wdata, 0);
      check("rst_i_rdata", i_ack_rdata, 0);
      check("rst_d_rdata", d_ack_rdata, 0);
    end
    if (exp_mval) begin
      check("mem_req_addr", mem_req_addr, t_addr);
      check("mem_req_cop", mem_req_cop, t_cop);
      check("mem_req_size", mem_req_size, t_size);
      check("mem_req_wdata", mem_req_wdata, t_wdata);
    end
    if (exp_i_ack) check("i_ack_rdata", i_ack_rdata, exp_rdata);
    if (exp_d_ack) check("d_ack_rdata", d_ack_rdata, exp_rdata);
  end

  // ---------------- stimulus ----------------
  int   ng, nd, n;
  logic order [3];

  task automatic idle_inputs();
    i_req_val = 0; i_req_addr = 0;
    d_req_val = 0; d_req_addr = 0; d_req_cop = 0; d_req_size = 0; d_req_wdata = 0;
    mem_req_rdy = 0; mem_ack = 0; mem_ack_rdata = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("reset_mval", mem_req_val, 0);
    check("reset_i_ack", i_ack, 0);
    check("reset_d_ack", d_ack, 0);
    check("reset_err", arb_err, 0);
    rst_n = 1;

    // Simultaneous I and D, D comes back for a second access.
    @(negedge clk);
    i_req_val = 1; i_req_addr = 32'h1000;
    d_req_val = 1; d_req_addr = 32'h2000; d_req_cop = 3'd0; d_req_size = 3'd2;
    mem_req_rdy = 1; mem_ack = 1; mem_ack_rdata = 32'h1111;
    ng = 0; nd = 0;
    for (int c = 0; c < 60 && ng < 3; c++) begin
      @(negedge clk);
      if (d_ack && ng < 3) begin
        order[ng] = 1; ng++; nd++;
        if (nd == 2) d_req_val = 0; else d_req_addr = 32'h2004;
      end
      if (i_ack && ng < 3) begin order[ng] = 0; ng++; i_req_val = 0; end
    end
    check("arb_grant_count", ng, 3);
    check("arb_order0", order[0], 1);
`ifdef CORE_MEM_ARB_RR_EN
    check("arb_order1", order[1], 0);
    check("arb_order2", order[2], 1);
`else
    check("arb_order1", order[1], 1);
    check("arb_order2", order[2], 0);
`endif
    idle_inputs();
    repeat (3) @(negedge clk);

    // Minimum-latency fetch: req in cycle 1, ack in cycle 4.
    i_req_val = 1; i_req_addr = 32'h100; mem_req_rdy = 1;
    @(negedge clk);
    check("lat_mval", mem_req_val, 1);
    check("lat_addr", mem_req_addr, 32'h100);
    check("lat_cop", mem_req_cop, 0);
    check("lat_size", mem_req_size, 2);
    @(negedge clk);
    check("lat_wait_mval", mem_req_val, 0);
    check("lat_no_ack_yet", i_ack, 0);
    mem_ack = 1; mem_ack_rdata = 32'hDEADBEEF; mem_req_rdy = 0;
    @(negedge clk);
    check("lat_i_ack", i_ack, 1);
    check("lat_i_rdata", i_ack_rdata, 32'hDEADBEEF);
    check("lat_d_ack", d_ack, 0);
    check("pin_model_i_ack", exp_i_ack, 1);
    check("pin_model_rdata", exp_rdata, 32'hDEADBEEF);
    i_req_val = 0; mem_ack = 0;
    @(negedge clk);
    check("lat_ack_once", i_ack, 0);

    // Memory not ready for 5 cycles.
    i_req_val = 1; i_req_addr = 32'h300; mem_req_rdy = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_mval", mem_req_val, 1);
      check("stall_addr", mem_req_addr, 32'h300);
      check("stall_cop", mem_req_cop, 0);
      check("stall_size", mem_req_size, 2);
    end
    mem_req_rdy = 1;
    @(negedge clk);
    check("stall_accepted", mem_req_val, 0);
    mem_req_rdy = 0; mem_ack = 1; mem_ack_rdata = 32'h77;
    @(negedge clk);
    check("stall_i_ack", i_ack, 1);
    check("stall_rdata", i_ack_rdata, 32'h77);
    i_req_val = 0; mem_ack = 0;
    @(negedge clk);

    // Timeout: no mem_ack at all.
    d_req_val = 1; d_req_addr = 32'h400; d_req_cop = 0; d_req_size = 2; d_req_wdata = 0;
    mem_req_rdy = 1;
    @(negedge clk);
    @(negedge clk);
    mem_req_rdy = 0;
    n = 0;
    while (!d_ack && n < 30) begin n++; @(negedge clk); end
    check("tmo_wait_cycles", n, TMO);
    check("tmo_d_ack", d_ack, 1);
    check("tmo_rdata", d_ack_rdata, 0);
    check("tmo_err", arb_err, 1);
    check("pin_model_err", exp_err, 1);
    d_req_val = 0; mem_ack = 1; mem_ack_rdata = 32'h1234;
    repeat (3) begin
      @(negedge clk);
      check("tmo_stray_d_ack", d_ack, 0);
      check("tmo_stray_err", arb_err, 0);
    end
    mem_ack = 0;
    @(negedge clk);

    // Reset during REQ: request drops without waiting for a clock edge.
    i_req_val = 1; i_req_addr = 32'h600;
    @(negedge clk);
    check("rreq_mval", mem_req_val, 1);
    i_req_val = 0;
    #2 rst_n = 0;
    #1;
    check("rreq_async_mval", mem_req_val, 0);
    check("rreq_async_addr", mem_req_addr, 0);
    @(negedge clk);
    rst_n = 1;

    // Reset during WAIT, then a stray mem_ack.
    i_req_val = 1; i_req_addr = 32'h500; mem_req_rdy = 1;
    @(negedge clk);
    @(negedge clk);
    i_req_val = 0; mem_req_rdy = 0;
    #2 rst_n = 0;
    #1;
    check("rwait_async_mval", mem_req_val, 0);
    check("rwait_async_i_ack", i_ack, 0);
    @(negedge clk);
    rst_n = 1;
    mem_ack = 1; mem_ack_rdata = 32'h99;
    repeat (3) begin
      @(negedge clk);
      check("rwait_stray_i_ack", i_ack, 0);
      check("rwait_stray_d_ack", d_ack, 0);
    end
    mem_ack = 0;
    i_req_val = 1; i_req_addr = 32'h504;
    @(negedge clk);
    check("rwait_idle_grant", mem_req_val, 1);
    mem_req_rdy = 1;
    @(negedge clk);
    mem_req_rdy = 0; mem_ack = 1; mem_ack_rdata = 32'h5;
    @(negedge clk);
    check("rwait_after_ack", i_ack, 1);
    i_req_val = 0; mem_ack = 0;
    @(negedge clk);

    // D write passes its fields through unchanged.
    d_req_val = 1; d_req_addr = 32'h700; d_req_cop = 3'b001; d_req_size = 3'b000;
    d_req_wdata = 32'h55;
    @(negedge clk);
    check("wr_addr", mem_req_addr, 32'h700);
    check("wr_cop", mem_req_cop, 3'b001);
    check("wr_size", mem_req_size, 3'b000);
    check("wr_wdata", mem_req_wdata, 32'h55);
    mem_req_rdy = 1;
    @(negedge clk);
    mem_req_rdy = 0; mem_ack = 1; mem_ack_rdata = 32'hA5A5;
    @(negedge clk);
    check("wr_d_ack", d_ack, 1);
    check("wr_rdata", d_ack_rdata, 32'hA5A5);
    check("wr_i_ack", i_ack, 0);
    d_req_val = 0; mem_ack = 0;
    @(negedge clk);
    check("wr_ack_once", d_ack, 0);

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (i_ack || !i_req_val) begin
        i_req_val  = (i_ack ? ($urandom % 2) : ($urandom % 4 == 0));
        i_req_addr = $urandom;
      end
      if (d_ack || !d_req_val) begin
        d_req_val   = (d_ack ? ($urandom % 2) : ($urandom % 4 == 0));
        d_req_addr  = $urandom;
        d_req_cop   = 3'($urandom);
        d_req_size  = 3'($urandom);
        d_req_wdata = $urandom;
      end
      mem_req_rdy   = ($urandom % 3 != 0);
      mem_ack       = ($urandom % 4 == 0);
      mem_ack_rdata = $urandom;
    end
    idle_inputs();
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
